// File: rtl/pong_game_ctrl_if.sv
// Signal bundle between the pong game sequencer and the rest of the pong design.
// The slave modport is the sequencer's view and the master modport is the view of the surrounding logic.
interface pong_game_ctrl_if #(
    parameter int BALL_W = 2
);
    logic [1:0]        btn;
    logic              hit;
    logic              miss;
    logic              timer_up;
    logic              timer_start;
    logic              graph_still;
    logic [1:0]        text_sel;
    logic [BALL_W-1:0] balls_left;
    logic [3:0]        score_d1;
    logic [3:0]        score_d0;
    logic [3:0]        hiscore_d1;
    logic [3:0]        hiscore_d0;

    modport slave (
        input  btn, hit, miss, timer_up,
        output timer_start, graph_still, text_sel, balls_left,
               score_d1, score_d0, hiscore_d1, hiscore_d0
    );

    modport master (
        output btn, hit, miss, timer_up,
        input  timer_start, graph_still, text_sel, balls_left,
               score_d1, score_d0, hiscore_d1, hiscore_d0
    );
endinterface

// File: rtl/pong_game_ctrl.sv
// Pong game-state sequencer: game phase, remaining balls, 2-digit BCD score, timer handshake.
// Define PONG_CTRL_HISCORE_EN to keep a high score; without it, hiscore_d1/d0 read 0.
module pong_game_ctrl #(
    parameter int BALLS  = 3,
    parameter int BALL_W = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    pong_game_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        NEWGAME = 2'd0,
        PLAY    = 2'd1,
        NEWBALL = 2'd2,
        OVER    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BALL_W-1:0] balls_q;
    logic [3:0]        d1_q, d0_q;
    logic              pressed;
    logic              timer_start;
    logic              graph_still;
    logic [1:0]        text_sel;

    assign pressed = |bus.btn;

    // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= NEWGAME;
        else          state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
    always_comb begin
        state_d     = state_q;
        timer_start = 1'b0;
        graph_still = 1'b1;
        text_sel    = 2'd1;
        unique case (state_q)
            NEWGAME: begin
                if (pressed) state_d = PLAY;
            end
            PLAY: begin
                graph_still = 1'b0;
                text_sel    = 2'd0;
                if (bus.miss) begin
                    timer_start = 1'b1;
                    state_d     = (balls_q == '0) ? OVER : NEWBALL;
                end
            end
            NEWBALL: begin
                text_sel = 2'd0;
                if (bus.timer_up && pressed) state_d = PLAY;
            end
            OVER: begin
                text_sel = 2'd2;
                if (bus.timer_up) state_d = NEWGAME;
            end
            default: state_d = NEWGAME;
        endcase
    end

    // Ball count and score; a miss takes precedence over a same-cycle hit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            balls_q <= BALL_W'(BALLS);
            d1_q    <= 4'd0;
            d0_q    <= 4'd0;
        end else begin
            if (state_q == NEWGAME && pressed) begin
                balls_q <= BALL_W'(BALLS - 1);
                d1_q    <= 4'd0;
                d0_q    <= 4'd0;
            end else if (state_q == PLAY) begin
                if (bus.miss) begin
                    if (balls_q != '0) balls_q <= balls_q - BALL_W'(1);
                end else if (bus.hit) begin
                    if (d0_q == 4'd9) begin
                        d0_q <= 4'd0;
                        d1_q <= (d1_q == 4'd9) ? 4'd0 : d1_q + 4'd1;
                    end else begin
                        d0_q <= d0_q + 4'd1;
                    end
                end
            end
        end
    end

`ifdef PONG_CTRL_HISCORE_EN
    logic [3:0] hi_d1_q, hi_d0_q;

    // Digits never exceed 9, so the packed BCD pair compares correctly as a plain 8-bit number.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hi_d1_q <= 4'd0;
            hi_d0_q <= 4'd0;
        end else if (state_q == PLAY && bus.miss && balls_q == '0
                     && {d1_q, d0_q} > {hi_d1_q, hi_d0_q}) begin
            hi_d1_q <= d1_q;
            hi_d0_q <= d0_q;
        end
    end

    assign bus.hiscore_d1 = hi_d1_q;
    assign bus.hiscore_d0 = hi_d0_q;
`else
    assign bus.hiscore_d1 = 4'd0;
    assign bus.hiscore_d0 = 4'd0;
`endif

    assign bus.timer_start = timer_start;
    assign bus.graph_still = graph_still;
    assign bus.text_sel    = text_sel;
    assign bus.balls_left  = balls_q;
    assign bus.score_d1    = d1_q;
    assign bus.score_d0    = d0_q;
endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Top-level game-state sequencer for the pong design. It tracks game phase, remaining balls and the 2-digit BCD score, and drives the shared countdown timer through timer_start, reading back timer_up. It freezes the graphics datapath between rallies and selects which text overlay the renderer shows.

Parameters:
BALLS, 3, balls per game; legal range 1..3.
BALL_W, 2, width of the balls_left counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
btn  in  2  paddle buttons, level, already debounced; "pressed" means btn != 0
hit  in  1  one-cycle pulse: ball struck paddle
miss  in  1  one-cycle pulse: ball passed paddle
timer_up  in  1  from timer: countdown reached 0
timer_start  out  1  to timer: reload countdown (1-cycle pulse)
graph_still  out  1  1 = freeze ball/paddle motion
text_sel  out  2  overlay: 0 score only, 1 rule/start, 2 game over
balls_left  out  BALL_W  balls remaining
score_d1  out  4  score tens digit, BCD
score_d0  out  4  score units digit, BCD
hiscore_d1  out  4  high-score tens digit, BCD (see Optional Feature)
hiscore_d0  out  4  high-score units digit, BCD

Behaviour:
- Single clock, async active-low reset on all state; no synchronous reset.
- Reset values: state=NEWGAME, balls_left=BALLS, score=00, hiscore=00, timer_start=0, graph_still=1, text_sel=1.
- States and transitions, evaluated every clk:
  - NEWGAME: graph_still=1, text_sel=1. If btn!=0, go to PLAY; balls_left<=BALLS-1; score<=00.
  - PLAY: graph_still=0, text_sel=0.
    - miss: timer_start=1 in the same cycle (combinational from state&miss).
    - miss with balls_left==0: go to OVER.
    - miss with balls_left!=0: balls_left<=balls_left-1 and go to NEWBALL.
    - hit without miss: score increments.
    - hit and miss together: miss wins, no increment.
  - NEWBALL: graph_still=1, text_sel=0. Go to PLAY when timer_up==1 and btn!=0 in the same cycle; balls_left is unchanged on this transition.
  - OVER: graph_still=1, text_sel=2. When timer_up==1, go to NEWGAME; score is held.
- timer_start is asserted only in the PLAY&miss cycle and is never asserted in other states.
- Score: 2-digit BCD, d0 increments.
  - d0==9 rolls to 0 and carries into d1.
  - 99 wraps to 00.
  - The digits never hold values above 9.
- Score changes only on a PLAY hit or on the NEWGAME→PLAY clear.
- balls_left never underflows; decrement happens only when it is nonzero.
- hit and miss are ignored outside PLAY.
- btn held continuously:
  - In NEWBALL, it starts play as soon as timer_up rises.
  - In NEWGAME, PLAY is entered in the first cycle after reset release.
- Reset mid-operation: immediate return to reset values in any state.
- Latency:
  - State, score and balls_left update on the clk edge after the qualifying input.
  - graph_still and text_sel are registered-state decodes, valid the same cycle as the state.

Optional Feature:
Macro PONG_CTRL_HISCORE_EN.
- Defined: on each transition PLAY→OVER, if the final score is greater than hiscore (BCD compare, d1 then d0), hiscore<=score. hiscore is cleared only by reset.
- Undefined: no hiscore register; hiscore_d1 and hiscore_d0 are tied to 0. The ports remain present.

Test Plan:
1. Reset, then btn=01 for 1 cycle -> PLAY next cycle, balls_left=2, score=00, graph_still=0, text_sel=0.
2. In PLAY, 12 hit pulses -> score_d1=1, score_d0=2. Next, preload 99 via 87 more hits, then 1 hit -> 00.
3. In PLAY with balls_left=2, miss -> timer_start=1 that cycle, then NEWBALL, balls_left=1, graph_still=1. btn=10 with timer_up=0 -> stays in NEWBALL. timer_up=1 with btn=10 -> PLAY.
4. Same cycle hit=1 and miss=1 at score 05 -> score stays 05, NEWBALL entered, timer_start=1.
5. Last ball: balls_left=0, miss -> OVER, text_sel=2. timer_up=1 -> NEWGAME with score held. Then btn -> score=00, balls_left=2.
6. With PONG_CTRL_HISCORE_EN, play games ending at 07 then 04 -> hiscore=07. Without the macro -> hiscore=00 throughout. Assert reset_n=0 mid-PLAY -> all outputs return to reset values asynchronously.
